// File: rtl/pipe_skid_if.sv
// Valid/ready/data bundle for one side of a pipeline stage.
// The master drives valid and data; the slave answers with ready.
interface pipe_skid_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_skid_register.sv
// Pipeline-stage register with a one-entry skid buffer and flush.
// in_ready comes straight from a flop, so no comb path from out_ready.
module pipe_skid_register #(
  parameter int             WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  pipe_skid_if.slave  up,
  pipe_skid_if.master down,
  input  logic       flush,
  output logic [1:0] occupancy
);

  // state = {s_v, m_v}; 2'b10 is unreachable
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] TWO   = 2'b11;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       occ_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_d;
  logic             main_ld;
  logic             skid_ld;
  logic             m_v;
  logic             s_v;
  logic             acc;
  logic             pop;

  assign m_v = state[0];
  assign s_v = state[1];

  assign acc = up.valid & ~s_v;
  assign pop = m_v & down.ready;

  assign up.ready   = ~s_v;
  assign down.valid = m_v;
  assign down.data  = main_q;

  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = up.data;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          main_ld   = 1'b1;
        end
      end
      ONE: begin
        unique case (1'b1)
          acc & pop: begin
            main_ld = 1'b1;
          end
          acc & ~pop: begin
            state_nxt = TWO;
            skid_ld   = 1'b1;
          end
          ~acc & pop: begin
            state_nxt = EMPTY;
          end
          ~acc & ~pop: begin
            state_nxt = ONE;
          end
        endcase
      end
      TWO: begin
        if (pop) begin
          state_nxt = ONE;
          main_ld   = 1'b1;
          main_d    = skid_q;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    // flush only clears valid bits; data regs may go stale
    if (flush) begin
      state_nxt = EMPTY;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
    end
    occ_nxt = {1'b0, state_nxt[0]} + {1'b0, state_nxt[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      occupancy <= 2'd0;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
    end else begin
      state     <= state_nxt;
      occupancy <= occ_nxt;
      if (main_ld) begin
        main_q <= main_d;
      end
      if (skid_ld) begin
        skid_q <= up.data;
      end
    end
  end

  a_legal: assert property (
    @(posedge clk) disable iff (reset)
    state != 2'b10
  );

  a_occ: assert property (
    @(posedge clk) disable iff (reset)
    occupancy == ({1'b0, m_v} + {1'b0, s_v})
  );

endmodule
